// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder
// Holds the request opcode enum, the responder FSM state type and the data width.
package mem_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_PUSH  = 2'd2,
    MEM_POP   = 2'd3
  } mem_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/stack_ptr.sv
// stack_ptr: 32-bit stack pointer with guarded push/pop update
// Ports: clk, rst_n (async active-low), push_i/pop_i (access strobes),
//        sp_o (current pointer), ovf_o (push would overflow), udf_o (pop would underflow).
module stack_ptr #(
  parameter logic [31:0] SP_INIT = 32'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  output logic [31:0] sp_o,
  output logic        ovf_o,
  output logic        udf_o
);
  logic [31:0] sp_q;
  assign sp_o  = sp_q;
  assign ovf_o = sp_q == 32'd0;
  assign udf_o = sp_q == SP_INIT;
  // Error cases leave the pointer untouched, so it stays inside [0, SP_INIT].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= SP_INIT;
    else if (push_i && !ovf_o) sp_q <= sp_q - 32'd1;
    else if (pop_i && !udf_o) sp_q <= sp_q + 32'd1;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated data memory and stack responder with valid/ready handshakes
// Ports: clk, rst_n (async active-low); request side req_valid_i/req_ready_o/req_op_i/
//        req_addr_i/req_wdata_i; response side rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o;
//        sp_out_o exposes the stack pointer.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1,
  parameter int SP_INIT     = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [15:0]       req_addr_i,
  input  logic [15:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [15:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic [31:0]       sp_out_o
);
  state_e              state_q;
  logic [3:0]          cnt_q;
  mem_op_e             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [31:0]         sp;
  logic                ovf, udf, access, we;
  logic [ADDR_W-1:0]   sp_a, wa, ra;
  logic [DATA_W-1:0]   rd;
  stack_ptr #(.SP_INIT(32'(SP_INIT))) u_sp (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (access && op_q == MEM_PUSH),
    .pop_i  (access && op_q == MEM_POP),
    .sp_o   (sp),
    .ovf_o  (ovf),
    .udf_o  (udf)
  );
  assign sp_a   = sp[ADDR_W-1:0];
  assign access = state_q == WAIT && cnt_q == 4'd0;
  // Gating with rst_n keeps a write from landing on the same edge reset asserts.
  assign we     = rst_n && access && (op_q == MEM_WRITE || (op_q == MEM_PUSH && !ovf));
  assign wa     = op_q == MEM_PUSH ? sp_a : addr_q;
  // POP reads the slot the pointer is about to move to.
  assign ra     = op_q == MEM_POP ? sp_a + ADDR_W'(1) : addr_q;
  assign rd     = mem[ra];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_q       <= MEM_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          op_q    <= mem_op_e'(req_op_i);
          addr_q  <= req_addr_i[ADDR_W-1:0];
          wdata_q <= req_wdata_i;
          cnt_q   <= 4'(WAIT_STATES);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          state_q    <= RESP;
          rsp_data_q <= (op_q == MEM_READ || (op_q == MEM_POP && !udf)) ? rd : '0;
          rsp_err_q  <= (op_q == MEM_PUSH && ovf) || (op_q == MEM_POP && udf);
        end
        RESP: if (rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign sp_out_o    = sp;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench with a behavioural memory/stack model
module tb_data_mem_responder;
  localparam int AW  = 12;
  localparam int WS  = 1;
  localparam int SPI = (1 << AW) - 1;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err;
  logic [1:0]  req_op = 0;
  logic [15:0] req_addr = 0, req_wdata = 0, rsp_data;
  logic [31:0] sp_out;
  logic        b_req_valid = 0, b_req_ready, b_rsp_valid, b_rsp_ready = 1, b_rsp_err;
  logic [1:0]  b_req_op = 0;
  logic [15:0] b_req_addr = 0, b_req_wdata = 0, b_rsp_data;
  logic [31:0] b_sp;
  always #5 clk = ~clk;
  data_mem_responder #(.ADDR_W(AW), .WAIT_STATES(WS), .SP_INIT(SPI)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .sp_out_o(sp_out));
  data_mem_responder #(.ADDR_W(AW), .WAIT_STATES(0), .SP_INIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_op_i(b_req_op), .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
    .rsp_err_o(b_rsp_err), .sp_out_o(b_sp));
  typedef struct {
    logic [15:0] data;
    logic        err;
    logic [31:0] sp;
    int          acc;
  } exp_t;
  exp_t        q[$];
  logic [15:0] ref_mem [int];
  int          ref_sp = SPI;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  bit          hold = 0, seen = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  // Monitor: every cycle a response is shown it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) fail("unexpected_rsp");
      else begin
        if (!seen) begin
          chk("latency", cyc - q[0].acc, WS + 1);
          seen = 1;
        end
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, q[0].data});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
        chk("sp_out", sp_out, q[0].sp);
        chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (rsp_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] wd);
    exp_t e;
    int   k = 0;
    int   ai;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail("req_ready_timeout");
      return;
    end
    req_valid = 1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    ai        = int'(a[AW-1:0]);
    e.data    = 16'd0;
    e.err     = 1'b0;
    case (op)
      2'd0: e.data = ref_mem[ai];
      2'd1: ref_mem[ai] = wd;
      2'd2: if (ref_sp == 0) e.err = 1'b1;
            else begin
              ref_mem[ref_sp] = wd;
              ref_sp--;
            end
      default: if (ref_sp == SPI) e.err = 1'b1;
            else begin
              ref_sp++;
              e.data = ref_mem[ref_sp];
            end
    endcase
    e.sp = ref_sp;
    @(posedge clk);
    #1;
    req_valid = 0;
    e.acc     = cyc;
    q.push_back(e);
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) fail("drain_timeout");
    repeat (2) @(negedge clk);
  endtask
  task automatic txn2(input logic [1:0] op, input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] xd, input logic xe, input logic [31:0] xsp);
    int k = 0;
    int acc;
    @(negedge clk);
    b_req_valid = 1;
    b_req_op    = op;
    b_req_addr  = a;
    b_req_wdata = wd;
    @(posedge clk);
    #1;
    b_req_valid = 0;
    acc         = cyc;
    @(negedge clk);
    while (!b_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!b_rsp_valid) fail("b_rsp_timeout");
    else begin
      chk("b_latency", cyc - acc, 1);
      chk("b_rsp_data", {16'd0, b_rsp_data}, {16'd0, xd});
      chk("b_rsp_err", {31'd0, b_rsp_err}, {31'd0, xe});
      chk("b_sp_out", b_sp, xsp);
    end
    @(posedge clk);
  endtask
  task automatic reset_checks();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_sp_out", sp_out, SPI);
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1;
    issue(2'd3, 16'h0, 16'h0);
    issue(2'd1, 16'h010, 16'hBEEF);
    issue(2'd0, 16'h010, 16'h0);
    issue(2'd2, 16'h0, 16'h1111);
    issue(2'd2, 16'h0, 16'h2222);
    issue(2'd3, 16'h0, 16'h0);
    issue(2'd3, 16'h0, 16'h0);
    issue(2'd1, 16'h030, 16'h1234);
    drain();
    hold = 1;
    issue(2'd0, 16'h030, 16'h0);
    repeat (5) begin
      @(negedge clk);
      req_valid = 1;
      req_op    = 2'd1;
      req_addr  = 16'h030;
      req_wdata = 16'hBAD0;
      chk("req_ready_while_held", {31'd0, req_ready}, 32'd0);
    end
    chk("rsp_valid_while_held", {31'd0, rsp_valid}, 32'd1);
    req_valid = 0;
    hold      = 0;
    issue(2'd0, 16'h030, 16'h0);
    repeat (150) begin
      logic [1:0]  op;
      logic [15:0] a;
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom_range(0, 63));
      if (op == 2'd0 && !ref_mem.exists(int'(a))) op = 2'd1;
      issue(op, a, 16'($urandom));
    end
    issue(2'd1, 16'h020, 16'h0000);
    drain();
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1;
    req_op    = 2'd1;
    req_addr  = 16'h020;
    req_wdata = 16'hDEAD;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    rst_n  = 0;
    ref_sp = SPI;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
    end
    chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
    issue(2'd0, 16'h020, 16'h0);
    issue(2'd3, 16'h0, 16'h0);
    drain();
    txn2(2'd1, 16'h000, 16'h0A0A, 16'h0000, 1'b0, 32'd2);
    txn2(2'd2, 16'h000, 16'h1111, 16'h0000, 1'b0, 32'd1);
    txn2(2'd2, 16'h000, 16'h2222, 16'h0000, 1'b0, 32'd0);
    txn2(2'd2, 16'h000, 16'h3333, 16'h0000, 1'b1, 32'd0);
    txn2(2'd0, 16'h000, 16'h0000, 16'h0A0A, 1'b0, 32'd0);
    txn2(2'd3, 16'h000, 16'h0000, 16'h2222, 1'b0, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
